// File: rtl/spi_adc_pkg.sv
// spi_adc_pkg: state encoding for the SPI ADC capture sequencer
package spi_adc_pkg;
  typedef enum logic [1:0] {IDLE, QUIET, SHIFT, DONE} state_t;
endpackage

// File: rtl/spi_adc_if.sv
// spi_adc_if: valid/ready stream carrying one sample word for all channels plus per-channel errors
interface spi_adc_if #(parameter int N_CH = 4, parameter int DATA_W = 12);
  logic [N_CH*DATA_W-1:0] data;
  logic                   valid;
  logic                   ready;
  logic [N_CH-1:0]        frame_err;
  modport master (output data, valid, frame_err, input ready);
  modport slave (input data, valid, frame_err, output ready);
endinterface

// File: rtl/spi_adc_sck_gen.sv
// spi_adc_sck_gen: divides clk into SPI half-period ticks and drives a registered, idle-high sck
module spi_adc_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  input  logic i_shift,
  input  logic i_shift_nxt,
  output logic o_tick,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  logic [DIV_W-1:0] r_div;
  logic             r_sck;
  assign o_tick = i_run && (r_div == DIV_W'(CLK_DIV - 1));
  assign o_rise = o_tick && i_shift && !r_sck;
  assign o_fall = o_tick && i_shift && r_sck;
  assign o_sck  = r_sck;
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_div <= '0;
      r_sck <= 1'b1;
    end else begin
      r_div <= (!i_run || o_tick) ? '0 : r_div + DIV_W'(1);
      r_sck <= !i_shift_nxt ? 1'b1 : (o_rise || o_fall) ? !r_sck : r_sck;
    end
endmodule

// File: rtl/spi_adc_capture.sv
// spi_adc_capture: multi-channel SPI ADC front end, one stream word per conversion.
// Define SPI_ADC_TESTPAT_EN to add i_test_mode, which substitutes a counting pattern for MISO data.
module spi_adc_capture
  import spi_adc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 2,
  parameter int CLK_DIV    = 2,
  parameter int CS_HIGH    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_enable,
  input  logic [N_CH-1:0] i_miso,
`ifdef SPI_ADC_TESTPAT_EN
  input  logic            i_test_mode,
`endif
  output logic            o_sck,
  output logic            o_cs_n,
  output logic            o_overrun,
  spi_adc_if.master       m_if
);
  localparam int CNT_W = $clog2(2*FRAME_BITS + CS_HIGH + 1);
  state_t                 r_st, w_st_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   w_tick, w_rise, w_fall, w_step, w_done, w_load;
  logic                   r_cs_n, r_valid, r_overrun;
  logic [N_CH*DATA_W-1:0] r_data, w_cap_data;
  logic [N_CH-1:0]        r_err, w_cap_err;

  if (LEAD_BITS + DATA_W > FRAME_BITS) begin : g_bad_cfg
    $error("spi_adc_capture: LEAD_BITS + DATA_W exceeds FRAME_BITS");
  end

  spi_adc_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk(clk), .reset_n(reset_n), .i_run(r_st != IDLE), .i_shift(r_st == SHIFT),
    .i_shift_nxt(w_st_nxt == SHIFT), .o_tick(w_tick), .o_sck(o_sck), .o_rise(w_rise), .o_fall(w_fall)
  );
  assign w_step = w_rise || w_fall;
  assign w_done = r_st == DONE;
  assign w_load = w_done && (!r_valid || m_if.ready);

  // DONE doubles as the first clk of the CS-high gap, keeping the period at (2*FRAME_BITS+CS_HIGH)*CLK_DIV
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      IDLE:    w_st_nxt = i_enable ? QUIET : IDLE;
      QUIET:   w_st_nxt = !i_enable ? IDLE : (w_tick && r_cnt >= CNT_W'(CS_HIGH - 1)) ? SHIFT : QUIET;
      SHIFT:   w_st_nxt = !i_enable ? IDLE : (w_step && r_cnt == CNT_W'(2*FRAME_BITS - 1)) ? DONE : SHIFT;
      default: w_st_nxt = i_enable ? QUIET : IDLE;
    endcase
    w_cnt_nxt = (w_st_nxt != r_st) ? CNT_W'(w_done && w_tick) : w_tick ? r_cnt + CNT_W'(1) : r_cnt;
  end

  always_ff @(posedge clk)
    if (!reset_n) begin
      r_st   <= IDLE;
      r_cnt  <= '0;
      r_cs_n <= 1'b1;
    end else begin
      r_st   <= w_st_nxt;
      r_cnt  <= w_cnt_nxt;
      r_cs_n <= w_st_nxt != SHIFT;
    end

`ifdef SPI_ADC_TESTPAT_EN
  logic [DATA_W-1:0] r_frame_cnt;
  always_ff @(posedge clk)
    if (!reset_n) r_frame_cnt <= '0;
    else if (w_done) r_frame_cnt <= r_frame_cnt + DATA_W'(1);
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [FRAME_BITS-1:0] r_sh;
    logic                  w_lead;
    always_ff @(posedge clk)
      if (!reset_n) r_sh <= '0;
      else if (w_rise) r_sh <= {r_sh[FRAME_BITS-2:0], i_miso[k]};
    if (LEAD_BITS > 0) begin : g_lead
      assign w_lead = |r_sh[FRAME_BITS-1 -: LEAD_BITS];
    end else begin : g_nolead
      assign w_lead = 1'b0;
    end
`ifdef SPI_ADC_TESTPAT_EN
    assign w_cap_data[k*DATA_W +: DATA_W] = i_test_mode ? r_frame_cnt + DATA_W'(k) : r_sh[FRAME_BITS-1-LEAD_BITS -: DATA_W];
    assign w_cap_err[k] = !i_test_mode && w_lead;
`else
    assign w_cap_data[k*DATA_W +: DATA_W] = r_sh[FRAME_BITS-1-LEAD_BITS -: DATA_W];
    assign w_cap_err[k] = w_lead;
`endif
  end

  always_ff @(posedge clk)
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_err     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= w_load || (r_valid && !m_if.ready);
      r_overrun <= w_done && r_valid && !m_if.ready;
      if (w_load) begin
        r_data <= w_cap_data;
        r_err  <= w_cap_err;
      end
    end

  assign o_cs_n         = r_cs_n;
  assign o_overrun      = r_overrun;
  assign m_if.valid     = r_valid;
  assign m_if.data      = r_data;
  assign m_if.frame_err = r_err;
endmodule

// File: tb/tb_spi_adc_capture.sv
// tb_spi_adc_capture: directed checks of framing, capture, lead-bit errors, backpressure, abort and reset
module tb_spi_adc_capture;
  import spi_adc_pkg::*;
  logic       clk = 1'b0, reset_n = 1'b0, enable = 1'b0, ready = 1'b1;
  logic [3:0] miso = '0;
  logic       sck, cs_n, overrun;
`ifdef SPI_ADC_TESTPAT_EN
  logic       test_mode = 1'b0;
`endif
  logic [15:0] words [4];
  int idx = 0;
  int n_chk = 0, n_err = 0;

  spi_adc_if #(.N_CH(4), .DATA_W(12)) s_if ();
  assign s_if.ready = ready;

  spi_adc_capture dut (
    .clk(clk), .reset_n(reset_n), .i_enable(enable), .i_miso(miso),
`ifdef SPI_ADC_TESTPAT_EN
    .i_test_mode(test_mode),
`endif
    .o_sck(sck), .o_cs_n(cs_n), .o_overrun(overrun), .m_if(s_if)
  );

  always #5 clk = ~clk;

  // ADC model: shifts the next frame bit out, MSB first, on each falling sck
  always @(negedge cs_n) idx = 0;
  always @(negedge sck) begin
    for (int k = 0; k < 4; k++) miso[k] = words[k][15 - idx];
    idx = idx + 1;
  end

  function automatic logic [15:0] frm(input logic [1:0] lead, input logic [11:0] s);
    return {lead, s, 2'b00};
  endfunction

  task automatic set_words(input logic [15:0] w0, w1, w2, w3);
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!s_if.valid && cyc < max);
    check(tag, s_if.valid, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " sck"}, sck, 1);
    check({tag, " cs_n"}, cs_n, 1);
    check({tag, " valid"}, s_if.valid, 0);
    check({tag, " data"}, s_if.data, 0);
    check({tag, " frame_err"}, s_if.frame_err, 0);
    check({tag, " overrun"}, overrun, 0);
    check({tag, " state"}, dut.r_st, IDLE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, n_ov, n_inval, n_chg, rises;
    logic prev;
    set_words(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;

    set_words(frm(2'b00, 12'hABC), frm(2'b00, 12'h123), frm(2'b00, 12'h000), frm(2'b00, 12'h000));
    enable = 1'b1;
    wait_valid("t1 first valid", 200, cyc);
    check("t1 data", s_if.data, 48'h000_000_123_ABC);
    check("t1 frame_err", s_if.frame_err, 4'b0000);
    wait_valid("t1 second valid", 100, cyc);
    check("t1 period", cyc, 68);
    check("t1 data again", s_if.data, 48'h000_000_123_ABC);

    words[2] = frm(2'b10, 12'hABC);
    wait_valid("t2 valid", 100, cyc);
    check("t2 period", cyc, 68);
    check("t2 data", s_if.data, 48'h000_ABC_123_ABC);
    check("t2 frame_err", s_if.frame_err, 4'b0100);

    @(negedge clk);
    ready = 1'b0;
    set_words(frm(2'b00, 12'h111), frm(2'b00, 12'h222), frm(2'b00, 12'h333), frm(2'b00, 12'h444));
    wait_valid("t3 held valid", 100, cyc);
    check("t3 held data", s_if.data, 48'h444_333_222_111);
    check("t3 held frame_err", s_if.frame_err, 4'b0000);
    set_words(frm(2'b00, 12'h0F0), frm(2'b00, 12'h00F), frm(2'b00, 12'hF00), frm(2'b00, 12'h5A5));
    n_ov = 0; n_inval = 0; n_chg = 0;
    repeat (140) begin
      @(negedge clk);
      n_ov    += int'(overrun);
      n_inval += int'(!s_if.valid);
      n_chg   += int'(s_if.data != 48'h444_333_222_111);
    end
    check("t3 overrun pulses", n_ov, 2);
    check("t3 valid dropped", n_inval, 0);
    check("t3 data changed", n_chg, 0);
    ready = 1'b1;
    @(negedge clk);
    check("t3 valid after accept", s_if.valid, 0);
    wait_valid("t3 next valid", 100, cyc);
    check("t3 next data", s_if.data, 48'h5A5_F00_00F_0F0);

    set_words(frm(2'b00, 12'h7FF), frm(2'b00, 12'h800), frm(2'b00, 12'hFFF), frm(2'b00, 12'h001));
    rises = 0; prev = sck; cyc = 0;
    while (!(rises == 10 && sck == 1'b0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!prev && sck) rises++;
      prev = sck;
    end
    check("t4 ten rising edges", rises, 10);
    check("t4 sck low before abort", sck, 0);
    enable = 1'b0;
    @(negedge clk);
    check("t4 abort sck", sck, 1);
    check("t4 abort cs_n", cs_n, 1);
    check("t4 abort state", dut.r_st, IDLE);
    n_inval = 0;
    repeat (150) begin
      @(negedge clk);
      n_inval += int'(s_if.valid);
    end
    check("t4 no valid after abort", n_inval, 0);
    ready = 1'b0;
    enable = 1'b1;
    wait_valid("t4 clean frame valid", 200, cyc);
    check("t4 clean data", s_if.data, 48'h001_FFF_800_7FF);
    check("t4 clean frame_err", s_if.frame_err, 4'b0000);

    cyc = 0;
    while (cs_n && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t5 cs_n low", cs_n, 0);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset("t5 mid-frame reset");
    reset_n = 1'b1;
    ready = 1'b1;
    wait_valid("t5 valid after reset", 200, cyc);
    check("t5 data after reset", s_if.data, 48'h001_FFF_800_7FF);

`ifdef SPI_ADC_TESTPAT_EN
    test_mode = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      logic [47:0] e;
      for (int k = 0; k < 4; k++) e[k*12 +: 12] = 12'(n + k);
      wait_valid("t6 valid", 200, cyc);
      check("t6 pattern data", s_if.data, e);
      check("t6 pattern frame_err", s_if.frame_err, 4'b0000);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
